inst_fetch_unit: RTL and testbench
==================================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 10: instruction memory word-address width.
REQ-002 Parameter INST_W, default 32: instruction width.
REQ-003 Parameter DATA_W, default 64: width of the packet sent to the fetch/decode stage.
REQ-004 Parameter INST_MEM_START, default 0: first instruction address, and the reset PC.
REQ-005 Parameter INST_MEM_END, default 511: last instruction address (data memory starts at 512).
REQ-006 Port clk, input, 1: clock; all state updates on the rising edge.
REQ-007 Port reset, input, 1: synchronous, active-high reset.
REQ-008 Port stall, input, 1: downstream cannot accept this cycle.
REQ-009 Port branch_valid, input, 1: redirect request.
REQ-010 Port branch_target, input, ADDR_W: redirect address.
REQ-011 Port imem_rd_en, output, 1: instruction memory read strobe.
REQ-012 Port imem_addr, output, ADDR_W: instruction memory read address.
REQ-013 Port imem_rdata, input, INST_W: read data, valid exactly 1 cycle after imem_rd_en.
REQ-014 Port inst_out, output, DATA_W: packet {zeros[DATA_W-1:ADDR_W+INST_W], pc[ADDR_W-1:0], inst[INST_W-1:0]}.
REQ-015 Port inst_valid, output, 1: inst_out holds a valid instruction.
REQ-016 Port fd_en, output, 1: load enable for the fetch/decode register; equals inst_valid & ~stall & ~branch_valid.

Function
REQ-017 The FSM SHALL have states BOOT, FETCH, HOLD and, only with the macro defined, HALT.
- BOOT lasts exactly 1 cycle after reset, then moves to FETCH.
REQ-018 In FETCH with stall low, imem_rd_en=1 and imem_addr=pc; pc advances by 1 each cycle.
- Throughput: 1 instruction per cycle after the 1-cycle memory latency.
REQ-019 Returned data SHALL appear on inst_out with inst_valid=1 in the cycle after the read, tagged with the PC it was read from.
REQ-020 When pc==INST_MEM_END, the next pc SHALL wrap to INST_MEM_START; no out-of-range address is ever issued.
REQ-021 stall=1 while inst_valid=1 SHALL move the FSM to HOLD:
- inst_out and inst_valid are frozen.
- imem_rd_en=0 and pc is held.
- Any read already in flight is captured into a 1-entry skid buffer.
REQ-022 When stall falls in HOLD:
- If the skid buffer is full, its content is presented next, then the FSM resumes FETCH.
- No instruction is lost or duplicated.
REQ-023 stall=1 while inst_valid=0 SHALL NOT freeze fetch; the first returned instruction is held.
REQ-024 branch_valid=1 SHALL take priority over stall in any state:
- The in-flight read, the skid buffer and inst_valid are discarded (inst_valid=0 next cycle).
- pc is set to branch_target, and the FSM goes to FETCH.
- The first target instruction is valid 2 cycles after branch_valid.
REQ-025 A branch_target above INST_MEM_END SHALL be wrapped modulo (INST_MEM_END-INST_MEM_START+1) from INST_MEM_START.
REQ-026 Simultaneous branch_valid and an instruction returning from memory: the returning instruction SHALL be dropped.

Reset
REQ-027 While reset=1:
- pc=INST_MEM_START, state=BOOT.
- imem_rd_en=0, imem_addr=0, inst_out=0, inst_valid=0, fd_en=0.
- The skid buffer is empty.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered instructions; no output is valid until the first post-reset fetch returns (cycle 3 after reset deasserts).

Configuration
REQ-029 Macro FETCH_HALT_DETECT_EN:
- Defined: an instruction with inst[31:26]==6'h3F is presented normally, then the FSM enters HALT.
- In HALT: imem_rd_en=0 and inst_valid=0 after the halt instruction is accepted; exit only via branch_valid or reset.
- Any read issued after the halt instruction is discarded.
- Not defined: opcode 6'h3F is an ordinary instruction and no HALT state exists.

Verification
REQ-030 Reset deasserts, memory returns word i = 32'hA000_0000+i, stall=0 -> inst_valid rises in cycle 3; inst_out=64'h0000_0000_A000_0000 with pc=0, then pc=1,2,... every cycle.
REQ-031 stall=1 for 3 cycles while inst_valid and a read is in flight (pc=5 shown, 6 in flight) -> inst_out holds pc=5; after release, pc=6 then pc=7 are shown, no gap or duplicate.
REQ-032 Fetch reaches pc=511 -> the next imem_addr is 0; inst_out shows pc=511 then pc=0.
REQ-033 branch_valid=1 with target=10'd100 during stall=1 with the skid buffer full -> inst_valid=0 next cycle; imem_addr=100; 2 cycles later inst_out shows pc=100.
REQ-034 With FETCH_HALT_DETECT_EN, word 4 = 32'hFC00_0000 -> pc=4 is presented, then inst_valid=0 and imem_rd_en=0 indefinitely; branch_valid with target=0 resumes fetch at pc=0. Without the macro, pc=5 follows normally.
REQ-035 Reset asserted for 1 cycle mid-stream while stall=1 -> all outputs 0 next cycle; the stream restarts at pc=0 in cycle 3 after reset deasserts.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: 1-cycle-latency imem reader with HOLD freeze, 1-entry skid buffer and branch redirect.
// Optional halt-opcode detection is compiled in with FETCH_HALT_DETECT_EN.
module inst_fetch_unit #(
  parameter int ADDR_W         = 10,
  parameter int INST_W         = 32,
  parameter int DATA_W         = 64,
  parameter int INST_MEM_START = 0,
  parameter int INST_MEM_END   = 511
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_rd_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst_out,
  output logic              inst_valid,
  output logic              fd_en
);

`ifdef FETCH_HALT_DETECT_EN
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } pkt_t;

  localparam logic [31:0] SPAN = 32'(INST_MEM_END - INST_MEM_START + 1);

  state_t            state;
  logic [ADDR_W-1:0] pc, rd_pc;
  logic              rd_q, hold_vld, skid_vld;
  pkt_t              hold_q, skid_q;

  pkt_t              ret_pkt, disp;
  logic              disp_vld, consume, rd_go;
  logic [ADDR_W-1:0] pc_inc, br_pc;
  logic [31:0]       tgt32;

  always_comb begin
    ret_pkt  = '{pc: rd_pc, inst: imem_rdata};
    // a frozen item always wins over live memory data
    disp     = hold_vld ? hold_q : ret_pkt;
    disp_vld = hold_vld | rd_q;
    consume  = disp_vld & ~stall & ~branch_valid;
    rd_go    = (state == FETCH) & ~branch_valid;
    pc_inc   = (pc == ADDR_W'(INST_MEM_END)) ? ADDR_W'(INST_MEM_START) : pc + ADDR_W'(1);
    tgt32    = 32'(branch_target);
    if (tgt32 > 32'(INST_MEM_END))
      br_pc = ADDR_W'((tgt32 - 32'(INST_MEM_START)) % SPAN + 32'(INST_MEM_START));
    else
      br_pc = branch_target;
  end

`ifdef FETCH_HALT_DETECT_EN
  logic halt_hit;
  assign halt_hit = consume & (disp.inst[31:26] == 6'h3F);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= BOOT;
      pc       <= ADDR_W'(INST_MEM_START);
      rd_q     <= 1'b0;
      rd_pc    <= '0;
      hold_vld <= 1'b0;
      skid_vld <= 1'b0;
      hold_q   <= '0;
      skid_q   <= '0;
    end else if (branch_valid) begin
      state    <= FETCH;
      pc       <= br_pc;
      rd_q     <= 1'b0;
      hold_vld <= 1'b0;
      skid_vld <= 1'b0;
`ifdef FETCH_HALT_DETECT_EN
    end else if (halt_hit) begin
      state    <= HALT;
      rd_q     <= 1'b0;
      hold_vld <= 1'b0;
      skid_vld <= 1'b0;
`endif
    end else begin
      rd_q <= rd_go;
      if (rd_go) begin
        rd_pc <= pc;
        pc    <= pc_inc;
      end
      if (hold_vld) begin
        if (consume) begin
          // next in line: skid first, else whatever is returning now
          if (skid_vld) begin
            hold_q   <= skid_q;
            skid_vld <= 1'b0;
          end else begin
            hold_vld <= rd_q;
            hold_q   <= ret_pkt;
          end
        end else if (rd_q) begin
          skid_vld <= 1'b1;
          skid_q   <= ret_pkt;
        end
      end else if (rd_q & stall) begin
        hold_vld <= 1'b1;
        hold_q   <= ret_pkt;
      end
      case (state)
        BOOT:    state <= FETCH;
        FETCH:   if (disp_vld & stall) state <= HOLD;
        HOLD:    if (!stall) state <= FETCH;
        default: state <= state;
      endcase
    end
  end

  assign imem_rd_en = rd_go & ~reset;
  assign imem_addr  = reset ? '0 : pc;
  assign inst_valid = disp_vld & ~reset;
  assign inst_out   = inst_valid ? DATA_W'(disp) : '0;
  assign fd_en      = inst_valid & ~stall & ~branch_valid;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed table-driven bench for inst_fetch_unit; each table row is one clock cycle of inputs and expected outputs.
module tb_inst_fetch_unit;
  localparam int AW = 10, IW = 32, DW = 64;

  logic          clk = 1'b0;
  logic          reset, stall, branch_valid;
  logic [AW-1:0] branch_target;
  logic          imem_rd_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [DW-1:0] inst_out;
  logic          inst_valid, fd_en;

  logic [IW-1:0] mem [0:1023];

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= imem_rd_en ? mem[imem_addr] : 32'hDEAD_BEEF;

  inst_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_valid(branch_valid),
    .branch_target(branch_target), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_out(inst_out), .inst_valid(inst_valid), .fd_en(fd_en)
  );

  typedef struct {
    logic          st, br;
    logic [AW-1:0] tgt;
    logic          v;
    logic [AW-1:0] pc;
    logic          rd;
    logic [AW-1:0] addr;
    logic          fd;
  } vec_t;

  vec_t tbl[$];
  int   total = 0, bad = 0;

  function automatic vec_t mk(int st, int br, int tgt, int v, int pc, int rd, int addr, int fd);
    vec_t t;
    t.st = st[0]; t.br = br[0]; t.tgt = AW'(tgt);
    t.v = v[0]; t.pc = AW'(pc); t.rd = rd[0]; t.addr = AW'(addr); t.fd = fd[0];
    return t;
  endfunction

  function automatic logic [DW-1:0] exp_pkt(logic v, logic [AW-1:0] pc);
    logic [DW-1:0] p;
    p = '0;
    if (v) p = {22'b0, pc, mem[pc]};
    return p;
  endfunction

  task automatic chk(string name, int cyc, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  // drive a row just after the edge, check at the falling edge, advance to next edge
  task automatic run_tbl(string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      stall = tbl[i].st; branch_valid = tbl[i].br; branch_target = tbl[i].tgt;
      @(negedge clk);
      chk({tag, ".valid"}, i + 1, 64'(inst_valid), 64'(tbl[i].v));
      chk({tag, ".out"},   i + 1, inst_out, exp_pkt(tbl[i].v, tbl[i].pc));
      chk({tag, ".rd_en"}, i + 1, 64'(imem_rd_en), 64'(tbl[i].rd));
      chk({tag, ".addr"},  i + 1, 64'(imem_addr), 64'(tbl[i].addr));
      chk({tag, ".fd_en"}, i + 1, 64'(fd_en), 64'(tbl[i].fd));
      @(posedge clk); #1;
    end
    tbl.delete();
  endtask

  task automatic reset_check(string tag);
    reset = 1'b1;
    @(negedge clk);
    chk({tag, ".valid"}, 0, 64'(inst_valid), 64'd0);
    chk({tag, ".out"},   0, inst_out, 64'd0);
    chk({tag, ".rd_en"}, 0, 64'(imem_rd_en), 64'd0);
    chk({tag, ".addr"},  0, 64'(imem_addr), 64'd0);
    chk({tag, ".fd_en"}, 0, 64'(fd_en), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; stall = 1'b0; branch_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    reset = 1'b1; stall = 1'b0; branch_valid = 1'b0; branch_target = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_check("rst");

    // startup stream, stall with read in flight, branch over full skid, wrap cases
    tbl.push_back(mk(0,0,0,   0,0,  0,0,  0));
    tbl.push_back(mk(0,0,0,   0,0,  1,0,  0));
    tbl.push_back(mk(0,0,0,   1,0,  1,1,  1));
    tbl.push_back(mk(0,0,0,   1,1,  1,2,  1));
    tbl.push_back(mk(0,0,0,   1,2,  1,3,  1));
    tbl.push_back(mk(0,0,0,   1,3,  1,4,  1));
    tbl.push_back(mk(0,0,0,   1,4,  1,5,  1));
    tbl.push_back(mk(1,0,0,   1,5,  1,6,  0));
    tbl.push_back(mk(1,0,0,   1,5,  0,7,  0));
    tbl.push_back(mk(1,0,0,   1,5,  0,7,  0));
    tbl.push_back(mk(0,0,0,   1,5,  0,7,  1));
    tbl.push_back(mk(0,0,0,   1,6,  1,7,  1));
    tbl.push_back(mk(0,0,0,   1,7,  1,8,  1));
    tbl.push_back(mk(0,0,0,   1,8,  1,9,  1));
    tbl.push_back(mk(1,0,0,   1,9,  1,10, 0));
    tbl.push_back(mk(1,0,0,   1,9,  0,11, 0));
    tbl.push_back(mk(1,1,100, 1,9,  0,11, 0));
    tbl.push_back(mk(0,0,0,   0,0,  1,100,0));
    tbl.push_back(mk(0,0,0,   1,100,1,101,1));
    tbl.push_back(mk(0,0,0,   1,101,1,102,1));
    tbl.push_back(mk(0,1,600, 1,102,0,103,0));
    tbl.push_back(mk(0,0,0,   0,0,  1,88, 0));
    tbl.push_back(mk(0,0,0,   1,88, 1,89, 1));
    tbl.push_back(mk(0,1,509, 1,89, 0,90, 0));
    tbl.push_back(mk(1,0,0,   0,0,  1,509,0));
    tbl.push_back(mk(1,0,0,   1,509,1,510,0));
    tbl.push_back(mk(0,0,0,   1,509,0,511,1));
    tbl.push_back(mk(0,0,0,   1,510,1,511,1));
    tbl.push_back(mk(0,0,0,   1,511,1,0,  1));
    tbl.push_back(mk(0,0,0,   1,0,  1,1,  1));
    run_tbl("main");

    // one-cycle reset mid-stream while stalled
    stall = 1'b1;
    reset_check("midrst");
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0, 1,0, 0));
    tbl.push_back(mk(0,0,0, 1,0, 1,1, 1));
    tbl.push_back(mk(0,0,0, 1,1, 1,2, 1));
    run_tbl("restart");

    // halt opcode at word 4
    mem[4] = 32'hFC00_0000;
    reset_check("hrst");
    tbl.push_back(mk(0,0,0, 0,0, 0,0, 0));
    tbl.push_back(mk(0,0,0, 0,0, 1,0, 0));
    tbl.push_back(mk(0,0,0, 1,0, 1,1, 1));
    tbl.push_back(mk(0,0,0, 1,1, 1,2, 1));
    tbl.push_back(mk(0,0,0, 1,2, 1,3, 1));
    tbl.push_back(mk(0,0,0, 1,3, 1,4, 1));
    tbl.push_back(mk(0,0,0, 1,4, 1,5, 1));
`ifdef FETCH_HALT_DETECT_EN
    tbl.push_back(mk(0,0,0, 0,0, 0,5, 0));
    tbl.push_back(mk(0,0,0, 0,0, 0,5, 0));
    tbl.push_back(mk(0,0,0, 0,0, 0,5, 0));
    tbl.push_back(mk(0,1,0, 0,0, 0,5, 0));
    tbl.push_back(mk(0,0,0, 0,0, 1,0, 0));
    tbl.push_back(mk(0,0,0, 1,0, 1,1, 1));
`else
    tbl.push_back(mk(0,0,0, 1,5, 1,6, 1));
    tbl.push_back(mk(0,0,0, 1,6, 1,7, 1));
`endif
    run_tbl("halt");
    mem[4] = 32'hA000_0004;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
